// File: rtl/sseg_display_decoder.sv
// Four-digit multiplexed seven-segment driver for a millisecond time count.
// Mode select chooses ms, SS.hh, MM:SS or HH:MM; anodes and segments are active low.
module sseg_display_decoder #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic [27:0] ms,
  output logic [6:0]  sseg,
  output logic [3:0]  an
);

  localparam logic [REFRESH_BITS-1:0] CNT_ONE = REFRESH_BITS'(1);

  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]              digit_idx_s;
  logic [27:0]             ms4_s, cs_s, sec_tot_s, sec_s, min_tot_s, min_s, hr_s;
  logic [27:0]             field_s;
  logic [3:0]              nibble_s;
  logic [3:0]              an_q, an_d;
  logic [6:0]              sseg_q, sseg_d;

  // Active-low {g,f,e,d,c,b,a} pattern for a BCD nibble; non-decimal codes blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign digit_idx_s = cnt_q[REFRESH_BITS-1 -: 2];

  // Time fields are derived by successive division so each quotient feeds the next.
  always_comb begin
    ms4_s     = ms % 28'd10000;
    cs_s      = (ms / 28'd10) % 28'd100;
    sec_tot_s = ms / 28'd1000;
    sec_s     = sec_tot_s % 28'd60;
    min_tot_s = sec_tot_s / 28'd60;
    min_s     = min_tot_s % 28'd60;
    hr_s      = (min_tot_s / 28'd60) % 28'd100;
  end

  // Pack the selected pair of fields as a four-decimal-digit value, then pick a digit.
  always_comb begin
    field_s  = 28'd0;
    nibble_s = 4'd0;
    case (sel)
      2'b00:   field_s = ms4_s;
      2'b01:   field_s = sec_s * 28'd100 + cs_s;
      2'b10:   field_s = min_s * 28'd100 + sec_s;
      2'b11:   field_s = hr_s  * 28'd100 + min_s;
      default: field_s = 28'd0;
    endcase
    case (digit_idx_s)
      2'd0:    nibble_s = 4'(field_s % 28'd10);
      2'd1:    nibble_s = 4'((field_s / 28'd10) % 28'd10);
      2'd2:    nibble_s = 4'((field_s / 28'd100) % 28'd10);
      2'd3:    nibble_s = 4'((field_s / 28'd1000) % 28'd10);
      default: nibble_s = 4'd0;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q + CNT_ONE;
    an_d   = ~(4'b0001 << digit_idx_s);
    sseg_d = seg_encode(nibble_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      an_q   <= 4'b1111;
      sseg_q <= 7'b1111111;
    end else begin
      cnt_q  <= cnt_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign sseg = sseg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_sseg_display_decoder.sv
// Randomised and directed bench for sseg_display_decoder with a 2-bit refresh counter.
module tb_sseg_display_decoder;

  localparam int RB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [27:0] ms  = 28'd0;
  logic [6:0]  sseg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int pos    = 0;
  int shown  = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  sseg_display_decoder #(.REFRESH_BITS(RB)) dut (
    .clk  (clk),
    .rst  (rst),
    .sel  (sel),
    .ms   (ms),
    .sseg (sseg),
    .an   (an)
  );

  // Digit k (0 = rightmost) of the four-digit reading for time m in mode s.
  function automatic int ref_digit(int m, int s, int k);
    int v;
    int p;
    case (s)
      0:       v = m % 10000;
      1:       v = ((m / 1000) % 60) * 100 + (m / 10) % 100;
      2:       v = ((m / 60000) % 60) * 100 + (m / 1000) % 60;
      3:       v = ((m / 3600000) % 100) * 100 + (m / 60000) % 60;
      default: v = 0;
    endcase
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return (v / p) % 10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    shown = pos;
    pos   = (pos + 1) % 4;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    #2 rst = 1'b1;
    #2;
    checks++;
    if (an !== 4'b1111 || sseg !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_init an=%b sseg=%b want 1111/1111111", an, sseg);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    pos = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_an = ~(4'b0001 << shown);
      checks++;
      if (an !== exp_an || sseg !== 7'b1000000) begin
        errors++;
        $display("FAIL reset_seq step=%0d an=%b sseg=%b want %b/1000000", i, an, sseg, exp_an);
      end
    end
    ms = 28'd1234;
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111 || sseg !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_async an=%b sseg=%b want 1111/1111111", an, sseg);
    end
    tick();
    checks++;
    if (an !== 4'b1111 || sseg !== 7'b1111111) begin
      errors++;
      $display("FAIL reset_hold an=%b sseg=%b want 1111/1111111", an, sseg);
    end
    rst = 1'b0;
    pos = 0;
    tick();
    checks++;
    if (an !== 4'b1110 || sseg !== seg_tab[4]) begin
      errors++;
      $display("FAIL reset_first an=%b sseg=%b want 1110/%b", an, sseg, seg_tab[4]);
    end
  endtask

  task automatic test_modes();
    int         tm [9] = '{1234, 83456, 83456, 3723000, 0, 0, 0, 0, 268435455};
    int         ts [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 3};
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int t = 0; t < 9; t++) begin
      ms  = 28'(tm[t]);
      sel = 2'(ts[t]);
      for (int i = 0; i < 4; i++) begin
        tick();
        exp_an  = ~(4'b0001 << shown);
        exp_seg = seg_tab[ref_digit(tm[t], ts[t], shown)];
        checks++;
        if (an !== exp_an || sseg !== exp_seg) begin
          errors++;
          $display("FAIL mode ms=%0d sel=%0d an=%b sseg=%b want %b/%b",
                   tm[t], ts[t], an, sseg, exp_an, exp_seg);
        end
      end
    end
  endtask

  task automatic test_midscan();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int         s;
    ms  = 28'd3723000;
    sel = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) sel = 2'b10;
      s = int'(sel);
      tick();
      exp_an  = ~(4'b0001 << shown);
      exp_seg = seg_tab[ref_digit(3723000, s, shown)];
      checks++;
      if (an !== exp_an || sseg !== exp_seg) begin
        errors++;
        $display("FAIL midscan step=%0d sel=%0d an=%b sseg=%b want %b/%b",
                 i, s, an, sseg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_counter();
    logic [6:0] exp_seg;
    for (int i = 0; i < 16; i++) begin
      ms  = 28'(i);
      sel = 2'(i / 4);
      tick();
      exp_seg = seg_tab[ref_digit(i, i / 4, shown)];
      checks++;
      if (sseg !== exp_seg || $countones(~an) != 1) begin
        errors++;
        $display("FAIL counter ms=%0d an=%b sseg=%b want one-hot-low/%b", i, an, sseg, exp_seg);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int         m;
    int         s;
    for (int i = 0; i < 300; i++) begin
      m   = int'($urandom_range(268435455, 0));
      s   = int'($urandom_range(3, 0));
      ms  = 28'(m);
      sel = 2'(s);
      tick();
      exp_an  = ~(4'b0001 << shown);
      exp_seg = seg_tab[ref_digit(m, s, shown)];
      checks++;
      if (an !== exp_an || sseg !== exp_seg) begin
        errors++;
        $display("FAIL random ms=%0d sel=%0d an=%b sseg=%b want %b/%b",
                 m, s, an, sseg, exp_an, exp_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_midscan();
    test_counter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
